// File: rtl/sumres_disp_pkg.sv
// rtl/sumres_disp_pkg.sv - shared constants and 7-segment patterns for the sum/result display
package sumres_disp_pkg;

    localparam int REFRESH_DIV_DEFAULT = 50000;

    // Active-high segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_MINUS = 7'h40;

    localparam logic [1:0] DIG_UNITS = 2'd0;
    localparam logic [1:0] DIG_TENS  = 2'd1;
    localparam logic [1:0] DIG_SIGN  = 2'd2;
    localparam logic [1:0] DIG_SPARE = 2'd3;

    function automatic logic [6:0] seg7_digit(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/sumres_seg7_dec.sv
// rtl/sumres_seg7_dec.sv - combinational BCD to active-high 7-segment decoder
module sumres_seg7_dec
    import sumres_disp_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    assign seg = seg7_digit(bcd);

endmodule

// File: rtl/sumres_display.sv
// rtl/sumres_display.sv - 4-digit multiplexed signed display of the add/sub result
// Optional: SUMRES_DISP_ZERO_BLANK_EN blanks a zero tens digit.
module sumres_display
    import sumres_disp_pkg::*;
#(
    parameter int REFRESH_DIV = REFRESH_DIV_DEFAULT,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_cy,
    input  logic [3:0] in_s,
    input  logic       in_sign,
    input  logic       in_op,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp,
    output logic       frame_tick
);

    localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    logic [PW-1:0] presc;
    logic [1:0]    idx;
    logic [4:0]    mag_q;
    logic          neg_q;
    logic [6:0]    seg_q;
    logic [3:0]    an_q;
    logic          frame_q;

    logic          slot_tick;
    logic          capture;
    logic [4:0]    mag_in;
    logic          neg_in;
    logic [1:0]    tens;
    logic [4:0]    tens_x10;
    logic [4:0]    units;
    logic [3:0]    dig_bcd;
    logic [6:0]    dig_seg;
    logic [6:0]    seg_next;
    logic [3:0]    an_next;

    assign slot_tick = (presc == PW'(REFRESH_DIV - 1));
    assign capture   = slot_tick && (idx == DIG_SPARE);

    // Subtraction results never carry into the magnitude; "-0" is suppressed
    assign mag_in = in_op ? {1'b0, in_s} : {in_cy, in_s};
    assign neg_in = in_op && in_sign && (mag_in != 5'd0);

    always_comb begin
        tens     = 2'd0;
        tens_x10 = 5'd0;
        if (mag_q >= 5'd30) begin
            tens     = 2'd3;
            tens_x10 = 5'd30;
        end else if (mag_q >= 5'd20) begin
            tens     = 2'd2;
            tens_x10 = 5'd20;
        end else if (mag_q >= 5'd10) begin
            tens     = 2'd1;
            tens_x10 = 5'd10;
        end
    end

    assign units   = mag_q - tens_x10;
    assign dig_bcd = (idx == DIG_TENS) ? {2'b00, tens} : units[3:0];

    sumres_seg7_dec u_dec (
        .bcd (dig_bcd),
        .seg (dig_seg)
    );

    always_comb begin
        seg_next = SEG_BLANK;
        case (idx)
            DIG_UNITS: seg_next = dig_seg;
`ifdef SUMRES_DISP_ZERO_BLANK_EN
            DIG_TENS:  seg_next = (tens == 2'd0) ? SEG_BLANK : dig_seg;
`else
            DIG_TENS:  seg_next = dig_seg;
`endif
            DIG_SIGN:  seg_next = neg_q ? SEG_MINUS : SEG_BLANK;
            default:   seg_next = SEG_BLANK;
        endcase
    end

    assign an_next = 4'b0001 << idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            presc   <= '0;
            idx     <= DIG_UNITS;
            mag_q   <= 5'd0;
            neg_q   <= 1'b0;
            seg_q   <= {7{ACTIVE_LOW}};
            an_q    <= {4{ACTIVE_LOW}};
            frame_q <= 1'b0;
        end else begin
            presc   <= slot_tick ? '0 : presc + 1'b1;
            if (slot_tick) begin
                idx <= idx + 2'd1;
            end
            if (capture) begin
                mag_q <= mag_in;
                neg_q <= neg_in;
            end
            frame_q <= capture;
            seg_q   <= seg_next ^ {7{ACTIVE_LOW}};
            an_q    <= an_next ^ {4{ACTIVE_LOW}};
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign dp         = ACTIVE_LOW;
    assign frame_tick = frame_q;

endmodule

// File: tb/tb_sumres_display.sv
// tb/tb_sumres_display.sv - directed self-checking bench for sumres_display
module tb_sumres_display;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_cy = 1'b0;
    logic [3:0] in_s = 4'd0;
    logic       in_sign = 1'b0;
    logic       in_op = 1'b0;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;
    logic       frame_tick;

    int vectors = 0;
    int miscompares = 0;

    // Active-low expected patterns
    localparam logic [6:0] S_OFF = 7'h7F;
    localparam logic [6:0] S_MIN = 7'h3F;
    localparam logic [6:0] S_0   = 7'h40;
    localparam logic [6:0] S_1   = 7'h79;
    localparam logic [6:0] S_2   = 7'h24;
    localparam logic [6:0] S_3   = 7'h30;
    localparam logic [6:0] S_5   = 7'h12;
    localparam logic [6:0] S_6   = 7'h02;
    localparam logic [6:0] S_9   = 7'h10;
`ifdef SUMRES_DISP_ZERO_BLANK_EN
    localparam logic [6:0] S_T0  = 7'h7F;
`else
    localparam logic [6:0] S_T0  = 7'h40;
`endif

    sumres_display #(.REFRESH_DIV(4), .ACTIVE_LOW(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_cy      (in_cy),
        .in_s       (in_s),
        .in_sign    (in_sign),
        .in_op      (in_op),
        .seg        (seg),
        .an         (an),
        .dp         (dp),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_an"}, {4'h0, an}, 8'h0F);
        check({tag, "_seg"}, {1'b0, seg}, {1'b0, S_OFF});
        check({tag, "_dp"}, {7'h0, dp}, 8'h01);
        check({tag, "_ft"}, {7'h0, frame_tick}, 8'h00);
    endtask

    task automatic wait_frame(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (frame_tick) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_frame_tick"}, {7'h0, seen}, 8'h01);
    endtask

    // Called on the negedge where frame_tick is high; walks one full frame
    task automatic check_frame(input string tag, input logic [6:0] u, input logic [6:0] t,
                               input logic [6:0] sg);
        @(negedge clk);
        check({tag, "_ft_low"}, {7'h0, frame_tick}, 8'h00);
        check({tag, "_an0"}, {4'h0, an}, 8'h0E);
        check({tag, "_units"}, {1'b0, seg}, {1'b0, u});
        repeat (4) @(negedge clk);
        check({tag, "_an1"}, {4'h0, an}, 8'h0D);
        check({tag, "_tens"}, {1'b0, seg}, {1'b0, t});
        repeat (4) @(negedge clk);
        check({tag, "_an2"}, {4'h0, an}, 8'h0B);
        check({tag, "_sign"}, {1'b0, seg}, {1'b0, sg});
        repeat (4) @(negedge clk);
        check({tag, "_an3"}, {4'h0, an}, 8'h07);
        check({tag, "_spare"}, {1'b0, seg}, {1'b0, S_OFF});
    endtask

    initial begin
        // 1: reset, then first slot tick after 4 clocks
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_an0", {4'h0, an}, 8'h0E);
        check("post_rst_units", {1'b0, seg}, {1'b0, S_0});
        repeat (3) @(negedge clk);
        check("slot_not_early", {4'h0, an}, 8'h0E);
        @(negedge clk);
        check("slot_after4", {4'h0, an}, 8'h0D);
        check("post_rst_tens", {1'b0, seg}, {1'b0, S_T0});

        // 2: 26 = carry + 10
        in_op = 1'b0; in_cy = 1'b1; in_s = 4'b1010; in_sign = 1'b0;
        wait_frame("add26");
        check_frame("add26", S_6, S_2, S_OFF);

        // Boundary: 31, largest add result
        in_s = 4'b1111;
        wait_frame("add31");
        check_frame("add31", S_1, S_3, S_OFF);

        // 3: subtraction, negative, carry ignored
        in_op = 1'b1; in_sign = 1'b1; in_cy = 1'b1; in_s = 4'b0011;
        wait_frame("sub_m3");
        check_frame("sub_m3", S_3, S_T0, S_MIN);

        // 4: no negative zero
        in_s = 4'd0;
        wait_frame("sub_m0");
        check_frame("sub_m0", S_0, S_T0, S_OFF);

        // 5: mid-frame input change is held off until the next capture
        in_op = 1'b0; in_cy = 1'b0; in_sign = 1'b0; in_s = 4'd5;
        wait_frame("hold5");
        @(negedge clk);
        check("hold5_units", {1'b0, seg}, {1'b0, S_5});
        repeat (4) @(negedge clk);
        check("hold5_an1", {4'h0, an}, 8'h0D);
        in_s = 4'd9;
        @(negedge clk);
        check("hold5_tens", {1'b0, seg}, {1'b0, S_T0});
        wait_frame("hold9");
        @(negedge clk);
        check("hold9_units", {1'b0, seg}, {1'b0, S_9});

        // 6: reset pulse mid-frame while index==2
        wait_frame("pre_rst");
        repeat (9) @(negedge clk);
        check("pre_rst_an2", {4'h0, an}, 8'h0B);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("mid_rst");
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_an0", {4'h0, an}, 8'h0E);
        check("mid_rst_held0", {1'b0, seg}, {1'b0, S_0});
        repeat (3) @(negedge clk);
        check("mid_rst_presc0", {4'h0, an}, 8'h0E);
        @(negedge clk);
        check("mid_rst_an1", {4'h0, an}, 8'h0D);
        check("mid_rst_tens0", {1'b0, seg}, {1'b0, S_T0});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
